// File: rtl/cpu_ctrl_pkg.sv
// Shared constants and control-bundle layout for the RV32I(+M) decode path.
// The bundle is a packed struct whose first field sits at the MSB end.
package cpu_ctrl_pkg;

  // ALU operations; the M-extension ops are consecutive so funct3 can index them.
  localparam logic [4:0] ALU_ADD    = 5'd0;
  localparam logic [4:0] ALU_SUB    = 5'd1;
  localparam logic [4:0] ALU_SLL    = 5'd2;
  localparam logic [4:0] ALU_SLT    = 5'd3;
  localparam logic [4:0] ALU_SLTU   = 5'd4;
  localparam logic [4:0] ALU_XOR    = 5'd5;
  localparam logic [4:0] ALU_SRL    = 5'd6;
  localparam logic [4:0] ALU_SRA    = 5'd7;
  localparam logic [4:0] ALU_OR     = 5'd8;
  localparam logic [4:0] ALU_AND    = 5'd9;
  localparam logic [4:0] ALU_MUL    = 5'd10;
  localparam logic [4:0] ALU_MULH   = 5'd11;
  localparam logic [4:0] ALU_MULHSU = 5'd12;
  localparam logic [4:0] ALU_MULHU  = 5'd13;
  localparam logic [4:0] ALU_DIV    = 5'd14;
  localparam logic [4:0] ALU_DIVU   = 5'd15;
  localparam logic [4:0] ALU_REM    = 5'd16;
  localparam logic [4:0] ALU_REMU   = 5'd17;
  localparam logic [4:0] ALU_PASSB  = 5'd18;

  localparam logic [1:0] MODE_USER    = 2'd0;
  localparam logic [1:0] MODE_SUPERV  = 2'd1;
  localparam logic [1:0] MODE_MACHINE = 2'd3;

  localparam logic [3:0] EXC_ILLEGAL    = 4'd2;
  localparam logic [3:0] EXC_BREAKPOINT = 4'd3;
  localparam logic [3:0] EXC_ECALL_U    = 4'd8;
  localparam logic [3:0] EXC_ECALL_S    = 4'd9;
  localparam logic [3:0] EXC_ECALL_M    = 4'd11;

  localparam logic [6:0] OP_LUI    = 7'h37;
  localparam logic [6:0] OP_AUIPC  = 7'h17;
  localparam logic [6:0] OP_JAL    = 7'h6F;
  localparam logic [6:0] OP_JALR   = 7'h67;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_IMM    = 7'h13;
  localparam logic [6:0] OP_REG    = 7'h33;
  localparam logic [6:0] OP_FENCE  = 7'h0F;
  localparam logic [6:0] OP_SYSTEM = 7'h73;

  // Bit offsets of each field inside the CTRL_W-wide bundle.
  localparam int OFS_RET_LEVEL  = 0;
  localparam int OFS_RET        = 2;
  localparam int OFS_CSR_OP     = 3;
  localparam int OFS_CSR_SRC    = 5;
  localparam int OFS_CSR_WRITE  = 6;
  localparam int OFS_CSR_READ   = 7;
  localparam int OFS_SLT_UNS    = 8;
  localparam int OFS_SLT        = 9;
  localparam int OFS_PC_IMM     = 10;
  localparam int OFS_PC_TO_REG  = 11;
  localparam int OFS_JALR       = 12;
  localparam int OFS_JUMP       = 13;
  localparam int OFS_BR_FUNCT   = 14;
  localparam int OFS_BRANCH     = 17;
  localparam int OFS_LOAD_UNS   = 18;
  localparam int OFS_MEM_SIZE   = 19;
  localparam int OFS_WRITE_REG  = 21;
  localparam int OFS_WRITE_MEM  = 22;
  localparam int OFS_MEM_TO_REG = 23;
  localparam int OFS_ALU_SRC    = 24;
  localparam int OFS_ALU_OP     = 25;
  localparam int CTRL_W         = 30;

  typedef struct packed {
    logic [4:0] alu_op;
    logic       alu_src;
    logic       mem_to_reg;
    logic       write_mem;
    logic       write_reg;
    logic [1:0] mem_size;
    logic       load_uns;
    logic       branch;
    logic [2:0] br_funct;
    logic       jump;
    logic       jalr;
    logic       pc_to_reg;
    logic       pc_imm;
    logic       slt;
    logic       slt_uns;
    logic       csr_read;
    logic       csr_write;
    logic       csr_src;
    logic [1:0] csr_op;
    logic       ret;
    logic [1:0] ret_level;
  } ctrl_t;

  function automatic logic [3:0] ecall_code(input logic [1:0] mode);
    case (mode)
      MODE_USER:   return EXC_ECALL_U;
      MODE_SUPERV: return EXC_ECALL_S;
      default:     return EXC_ECALL_M;
    endcase
  endfunction

endpackage

// File: rtl/decode_ctrl_comb.sv
// Pure combinational RV32I(+M) decoder: instruction and privilege in,
// control bundle and exception info out. Trapping entries carry no control.
module decode_ctrl_comb
  import cpu_ctrl_pkg::*;
#(
  parameter bit ENABLE_M = 1'b0
) (
  input  logic [31:0]       instr,
  input  logic [1:0]        mode,
  output logic [CTRL_W-1:0] ctrl,
  output logic              excep,
  output logic [3:0]        excep_code
);

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [11:0] funct12;

  assign opcode  = instr[6:0];
  assign rd      = instr[11:7];
  assign funct3  = instr[14:12];
  assign rs1     = instr[19:15];
  assign funct7  = instr[31:25];
  assign funct12 = instr[31:20];

  ctrl_t      c;
  logic       illegal;
  logic       trap;
  logic [3:0] trap_code;
  logic [1:0] ret_lvl;

  always_comb begin
    c         = '0;
    illegal   = 1'b0;
    trap      = 1'b0;
    trap_code = '0;
    ret_lvl   = '0;
    case (opcode)
      OP_LUI: begin
        c.alu_op = ALU_PASSB; c.alu_src = 1'b1; c.write_reg = 1'b1;
      end
      OP_AUIPC: begin
        c.pc_imm = 1'b1; c.write_reg = 1'b1;
      end
      OP_JAL: begin
        c.jump = 1'b1; c.pc_to_reg = 1'b1; c.write_reg = 1'b1;
      end
      OP_JALR: begin
        if (funct3 != 3'd0) illegal = 1'b1;
        c.jump = 1'b1; c.jalr = 1'b1; c.pc_to_reg = 1'b1;
        c.write_reg = 1'b1; c.alu_src = 1'b1; c.alu_op = ALU_ADD;
      end
      OP_BRANCH: begin
        if (funct3 == 3'd2 || funct3 == 3'd3) illegal = 1'b1;
        c.branch = 1'b1; c.br_funct = funct3; c.alu_op = ALU_SUB;
      end
      OP_LOAD: begin
        if (funct3[1:0] == 2'd3 || funct3 >= 3'd6) illegal = 1'b1;
        c.mem_to_reg = 1'b1; c.write_reg = 1'b1; c.alu_src = 1'b1;
        c.mem_size = funct3[1:0] + 2'd1; c.load_uns = funct3[2];
      end
      OP_STORE: begin
        if (funct3 >= 3'd3) illegal = 1'b1;
        c.write_mem = 1'b1; c.alu_src = 1'b1; c.mem_size = funct3[1:0] + 2'd1;
      end
      OP_IMM: begin
        c.alu_src = 1'b1; c.write_reg = 1'b1;
        case (funct3)
          3'd0: c.alu_op = ALU_ADD;
          3'd1: begin c.alu_op = ALU_SLL; if (funct7 != 7'h00) illegal = 1'b1; end
          3'd2: begin c.alu_op = ALU_SLT; c.slt = 1'b1; end
          3'd3: begin c.alu_op = ALU_SLTU; c.slt_uns = 1'b1; end
          3'd4: c.alu_op = ALU_XOR;
          3'd5: begin
            if (funct7 == 7'h00)      c.alu_op = ALU_SRL;
            else if (funct7 == 7'h20) c.alu_op = ALU_SRA;
            else                      illegal = 1'b1;
          end
          3'd6: c.alu_op = ALU_OR;
          default: c.alu_op = ALU_AND;
        endcase
      end
      OP_REG: begin
        c.write_reg = 1'b1;
        if (funct7 == 7'h00) begin
          case (funct3)
            3'd0: c.alu_op = ALU_ADD;
            3'd1: c.alu_op = ALU_SLL;
            3'd2: begin c.alu_op = ALU_SLT; c.slt = 1'b1; end
            3'd3: begin c.alu_op = ALU_SLTU; c.slt_uns = 1'b1; end
            3'd4: c.alu_op = ALU_XOR;
            3'd5: c.alu_op = ALU_SRL;
            3'd6: c.alu_op = ALU_OR;
            default: c.alu_op = ALU_AND;
          endcase
        end else if (funct7 == 7'h20 && funct3 == 3'd0) begin
          c.alu_op = ALU_SUB;
        end else if (funct7 == 7'h20 && funct3 == 3'd5) begin
          c.alu_op = ALU_SRA;
        end else if (funct7 == 7'h01 && ENABLE_M) begin
          c.alu_op = ALU_MUL + {2'b00, funct3};
        end else begin
          illegal = 1'b1;
        end
      end
      OP_FENCE: ;  // no ordering to enforce in an in-order pipe: decodes as a nop
      OP_SYSTEM: begin
        if (funct3 == 3'd0) begin
          case (funct12)
            12'h000: begin trap = 1'b1; trap_code = ecall_code(mode); end
            12'h001: begin trap = 1'b1; trap_code = EXC_BREAKPOINT; end
            12'h002, 12'h102, 12'h302: begin
              // uret/sret/mret differ only in bits [9:8], which are the target level.
              ret_lvl = funct12[9:8];
              if (mode >= ret_lvl) begin c.ret = 1'b1; c.ret_level = ret_lvl; end
              else illegal = 1'b1;
            end
            default: illegal = 1'b1;
          endcase
        end else if (funct3 == 3'd4) begin
          illegal = 1'b1;
        end else begin
          c.csr_src   = funct3[2];
          c.csr_op    = funct3[1:0] - 2'd1;
          c.csr_read  = !(funct3[1:0] == 2'd1 && rd == 5'd0);
          c.csr_write = !(funct3[1:0] != 2'd1 && rs1 == 5'd0);
          c.write_reg = c.csr_read;
          if (funct12[9:8] > mode) illegal = 1'b1;
          if (funct12[11:10] == 2'b11 && c.csr_write) illegal = 1'b1;
        end
      end
      default: illegal = 1'b1;
    endcase
    if (illegal) begin
      trap      = 1'b1;
      trap_code = EXC_ILLEGAL;
    end
  end

  assign ctrl       = trap ? '0 : c;
  assign excep      = trap;
  assign excep_code = trap_code;

endmodule

// File: rtl/decode_ctrl_q.sv
// Registered decoder: decodes on the way in and queues bundles in a DEPTH-entry
// FIFO between IF/ID and ID/EX; outputs come directly from the head entry.
module decode_ctrl_q
  import cpu_ctrl_pkg::*;
#(
  parameter bit ENABLE_M = 1'b0,
  parameter int DEPTH    = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       instr,
  input  logic [1:0]        mode,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [31:0]       out_instr,
  output logic              out_excep,
  output logic [3:0]        out_excep_code
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  logic [CTRL_W-1:0] dec_ctrl;
  logic              dec_excep;
  logic [3:0]        dec_code;

  decode_ctrl_comb #(.ENABLE_M(ENABLE_M)) u_dec (
    .instr      (instr),
    .mode       (mode),
    .ctrl       (dec_ctrl),
    .excep      (dec_excep),
    .excep_code (dec_code)
  );

  logic [CTRL_W-1:0] ctrl_mem  [DEPTH];
  logic [31:0]       instr_mem [DEPTH];
  logic              excep_mem [DEPTH];
  logic [3:0]        code_mem  [DEPTH];

  logic [PW-1:0] wr_ptr_reg, wr_ptr_next;
  logic [PW-1:0] rd_ptr_reg, rd_ptr_next;
  logic [CW-1:0] count_reg, count_next;
  logic          push, pop, wr_en;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign in_ready  = count_reg < CW'(DEPTH);
  assign out_valid = count_reg != '0;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  // A push coinciding with rst/flush is dropped, so it must not touch storage either.
  assign wr_en     = push && !flush && !rst;

  always_comb begin
    wr_ptr_next = push ? ptr_inc(wr_ptr_reg) : wr_ptr_reg;
    rd_ptr_next = pop  ? ptr_inc(rd_ptr_reg) : rd_ptr_reg;
    count_next  = count_reg + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      ctrl_mem[wr_ptr_reg]  <= dec_ctrl;
      instr_mem[wr_ptr_reg] <= instr;
      excep_mem[wr_ptr_reg] <= dec_excep;
      code_mem[wr_ptr_reg]  <= dec_code;
    end
  end

  assign out_ctrl       = out_valid ? ctrl_mem[rd_ptr_reg]  : '0;
  assign out_instr      = out_valid ? instr_mem[rd_ptr_reg] : '0;
  assign out_excep      = out_valid ? excep_mem[rd_ptr_reg] : 1'b0;
  assign out_excep_code = out_valid ? code_mem[rd_ptr_reg]  : '0;

endmodule

// File: doc/decode_ctrl_q.md
Name: decode_ctrl_q

Overview:
- Registered, parametrised successor to the combinational control unit.
- Decodes one 32-bit RV32I(+optional M) instruction per accepted beat into a packed control bundle plus exception info.
- Buffers results in a DEPTH-entry FIFO with valid/ready on both sides, sitting between the IF/ID and ID/EX pipeline boundaries.
- Adds a flush, full CSR privilege/read-only checks, ebreak, CSR read/write side-effect suppression, and full M-extension decode.

Parameters:
- ENABLE_M, 0, 1 = decode the M extension (funct7=0x01); 0 = those encodings are illegal.
- DEPTH, 2, FIFO entries; a power of two, 1..8.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- flush  in  1  drop all buffered entries; synchronous
- in_valid  in  1  instruction available
- in_ready  out  1  FIFO can accept this cycle
- instr  in  32  raw instruction
- mode  in  2  current privilege, sampled with instr (USER=0, SUPERV=1, MACHINE=3)
- out_valid  out  1  head entry valid
- out_ready  in  1  consumer takes head
- out_ctrl  out  CTRL_W  packed control bundle (layout in package)
- out_instr  out  32  instruction of head entry
- out_excep  out  1  head raises exception
- out_excep_code  out  4  mcause code of head

Behaviour:
- Clock/reset:
  - Single clock clk.
  - rst is synchronous and active-high: on the edge where rst=1, count/pointers are set to 0 and out_valid=0.
  - While empty, out_ctrl, out_instr, out_excep and out_excep_code are forced to 0. in_ready=1 after reset.
- Handshake:
  - Push when in_valid&&in_ready. Pop when out_valid&&out_ready.
  - in_ready = (count<DEPTH); it does not depend on out_ready.
  - Full with pop pending: in_ready stays 0 that cycle.
  - Push and pop in the same cycle leave count unchanged.
- Latency: an instruction pushed at edge t is visible at the head at t+1 if the FIFO was empty. Decode is combinational before the write, and outputs come straight from the head entry register.
- Flush:
  - At the edge, count and pointers are cleared. A push in the same cycle is discarded.
  - rst has priority over flush; flush has priority over push/pop.
- Pointers wrap modulo DEPTH; count is clog2(DEPTH)+1 bits.
- Control bundle fields: alu_op[4:0], alu_src, mem_to_reg, write_mem, write_reg, mem_size[1:0] (1=B, 2=H, 3=W), load_uns, branch, br_funct[2:0], jump, jalr, pc_to_reg, pc_imm, slt, slt_uns, csr_read, csr_write, csr_src, csr_op[1:0], ret, ret_level[1:0].
- Decode rules:
  - Opcodes follow RV32I. Any unlisted opcode, or an unlisted funct3/funct7 for an R/I-shift/load/store/branch, is illegal (code 2). This differs from the old NONE behaviour.
  - R-type funct7=0x01:
    - ENABLE_M=1: funct3 0..7 map to MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
    - ENABLE_M=0: illegal.
  - CSR (0x73, funct3!=0), addr = instr[31:20]:
    - csr_read = 0 when funct3 is RW/RWI and rd=0.
    - csr_write = 0 when funct3 is RS/RC/RSI/RCI and rs1/uimm=0.
    - funct3=4 is illegal.
    - addr[9:8] > mode → illegal.
    - addr[11:10]==2'b11 with csr_write=1 → illegal.
  - SYSTEM funct3=0:
    - ecall → code 8/9/11 by mode.
    - ebreak (funct12=1) → code 3.
    - mret/sret/uret → ret=1 with ret_level = 3/1/0 if mode>=level, else illegal.
    - Any other funct12 → illegal.
- Exception entries: all control fields are 0 except excep and code. The entry is still queued in order.

Decomposition:
- Shared package cpu_ctrl_pkg holds:
  - the ALU op constants (reusing the existing `ADD..` values and adding MULH, MULHSU, MULHU, DIV, REM);
  - mode constants;
  - exception codes;
  - control-bundle field offsets and CTRL_W;
  - opcode constants.
- One sub-module, decode_ctrl_comb: the pure combinational decoder from instr+mode to ctrl/excep.
- The top-level module holds the FIFO.

Test Plan:
- Reset, then push 0x00500093 (addi x1,x0,5) with out_ready=1 → next cycle out_valid=1, alu_op=ADD, alu_src=1, write_reg=1, excep=0; the cycle after, out_valid=0.
- out_ready=0, push 3 instrs with DEPTH=2 → in_ready drops after 2 pushes; the third is held. Releasing out_ready yields FIFO order with no loss or duplication.
- mode=USER, push 0x300110F3 (csrrw x1,mstatus,x2) → excep=1, code=2. mode=MACHINE → csr_read=1, csr_write=1, csr_op=0.
- Push 0x30200073 (mret) at mode=SUPERV → code 2. Push 0x00000073 (ecall) at mode=USER → code 8. Push 0x00100073 (ebreak) → code 3.
- Push 0x022081B3 (mul x3,x1,x2): ENABLE_M=0 → code 2; ENABLE_M=1 → alu_op=MUL, write_reg=1.
- Fill the FIFO, then assert flush with in_valid=1 → next cycle out_valid=0 and in_ready=1. Assert rst mid-stream → same result, outputs all 0.
